lcd_read_fsm: RTL and testbench

//  Read-side controller for the HD44780-style character LCD bus; the counterpart of the LCD write sequencer.

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_delay_counter.sv | 28 ++
 rtl/lcd_read_fsm.sv | 191 +++++++++++++++++++
 tb/tb_lcd_read_fsm.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared encodings and default timing for the LCD bus controllers
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_E_HIGH = 3'd2,
        ST_E_LOW  = 3'd3,
        ST_CHECK  = 3'd4,
        ST_RESULT = 3'd5
    } lcd_rd_state_e;

    localparam int T_AS_DEF      = 3;
    localparam int T_EH_DEF      = 25;
    localparam int T_EL_DEF      = 25;
    localparam int MAX_POLLS_DEF = 255;

    // Delay counter width; every timing constant must fit below 2**DLY_W.
    localparam int DLY_W = 8;

    localparam logic RS_INSTR = 1'b0;
    localparam logic RS_DATA  = 1'b1;

    localparam int BF_BIT = 7;

endpackage

// File: rtl/lcd_delay_counter.sv
// rtl/lcd_delay_counter.sv - loadable down-counter used to time LCD bus phases
module lcd_delay_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    // Load wins over counting; the count parks at zero until reloaded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_read_fsm.sv
// rtl/lcd_read_fsm.sv - timed HD44780 read cycles with optional busy-flag polling
module lcd_read_fsm
    import lcd_pkg::*;
#(
    parameter int T_AS      = T_AS_DEF,
    parameter int T_EH      = T_EH_DEF,
    parameter int T_EL      = T_EL_DEF,
    parameter int MAX_POLLS = MAX_POLLS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs_sel,
    input  logic       busy_poll,
    input  logic [7:0] lcd_db_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       rd_active,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic [6:0] addr_cnt,
    output logic       valid,
    output logic       timeout,
    output logic       done
);

    // The counter loads N-1 so a phase lasts exactly N cycles.
    localparam logic [DLY_W-1:0] LD_AS = DLY_W'(T_AS - 1);
    localparam logic [DLY_W-1:0] LD_EH = DLY_W'(T_EH - 1);
    localparam logic [DLY_W-1:0] LD_EL = DLY_W'(T_EL - 1);
    localparam logic [7:0]       MAX_P = 8'(MAX_POLLS);

    lcd_rd_state_e    state_q, state_d;
    logic             rs_lat_q, rs_lat_d;
    logic             poll_lat_q, poll_lat_d;
    logic [7:0]       poll_cnt_q, poll_cnt_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             bf_q, bf_d;
    logic [6:0]       ac_q, ac_d;
    logic             timeout_q, timeout_d;
    logic             rs_q, rs_d;
    logic             rw_q, rw_d;
    logic             e_q, e_d;
    logic             active_q, active_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             polling;
    logic             dly_load, dly_en, dly_zero;
    logic [DLY_W-1:0] dly_val;

    lcd_delay_counter #(
        .WIDTH(DLY_W)
    ) u_dly (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (dly_load),
        .load_val_i (dly_val),
        .en_i       (dly_en),
        .zero_o     (dly_zero)
    );

    // Busy polling only makes sense on instruction-register reads.
    assign polling = poll_lat_q && (rs_lat_q == RS_INSTR);

    // Next-state logic; bus outputs are derived from the next state so they are registered.
    always_comb begin
        state_d    = state_q;
        rs_lat_d   = rs_lat_q;
        poll_lat_d = poll_lat_q;
        poll_cnt_d = poll_cnt_q;
        rd_data_d  = rd_data_q;
        bf_d       = bf_q;
        ac_d       = ac_q;
        timeout_d  = timeout_q;
        dly_load   = 1'b0;
        dly_en     = 1'b0;
        dly_val    = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rs_lat_d   = rs_sel;
                    poll_lat_d = busy_poll;
                    poll_cnt_d = '0;
                    timeout_d  = 1'b0;
                    dly_load   = 1'b1;
                    dly_val    = LD_AS;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                dly_en = 1'b1;
                if (dly_zero) begin
                    dly_load = 1'b1;
                    dly_val  = LD_EH;
                    state_d  = ST_E_HIGH;
                end
            end
            ST_E_HIGH: begin
                dly_en = 1'b1;
                if (dly_zero) begin
                    rd_data_d  = lcd_db_in;
                    poll_cnt_d = poll_cnt_q + 8'd1;
                    dly_load   = 1'b1;
                    dly_val    = LD_EL;
                    state_d    = ST_E_LOW;
                end
            end
            ST_E_LOW: begin
                dly_en = 1'b1;
                if (dly_zero) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (polling && rd_data_q[BF_BIT] && (poll_cnt_q < MAX_P)) begin
                    dly_load = 1'b1;
                    dly_val  = LD_AS;
                    state_d  = ST_SETUP;
                end else begin
                    timeout_d = polling && rd_data_q[BF_BIT];
                    if (rs_lat_q == RS_INSTR) begin
                        bf_d = rd_data_q[BF_BIT];
                        ac_d = rd_data_q[6:0];
                    end
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        e_d      = (state_d == ST_E_HIGH);
        rw_d     = (state_d != ST_IDLE);
        active_d = (state_d != ST_IDLE);
        done_d   = (state_d == ST_IDLE);
        valid_d  = (state_d == ST_RESULT);
        rs_d     = (state_d == ST_IDLE) ? RS_INSTR : rs_lat_d;
    end

    // State and output registers; reset drops E and RW immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rs_lat_q   <= RS_INSTR;
            poll_lat_q <= 1'b0;
            poll_cnt_q <= '0;
            rd_data_q  <= '0;
            bf_q       <= 1'b0;
            ac_q       <= '0;
            timeout_q  <= 1'b0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            e_q        <= 1'b0;
            active_q   <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            rs_lat_q   <= rs_lat_d;
            poll_lat_q <= poll_lat_d;
            poll_cnt_q <= poll_cnt_d;
            rd_data_q  <= rd_data_d;
            bf_q       <= bf_d;
            ac_q       <= ac_d;
            timeout_q  <= timeout_d;
            rs_q       <= rs_d;
            rw_q       <= rw_d;
            e_q        <= e_d;
            active_q   <= active_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign lcd_rs    = rs_q;
    assign lcd_rw    = rw_q;
    assign lcd_e     = e_q;
    assign rd_active = active_q;
    assign rd_data   = rd_data_q;
    assign busy_flag = bf_q;
    assign addr_cnt  = ac_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign done      = done_q;

endmodule

// File: tb/tb_lcd_read_fsm.sv
// tb/tb_lcd_read_fsm.sv - directed self-checking bench for lcd_read_fsm
module tb_lcd_read_fsm;

    localparam int T_AS = 3;
    localparam int T_EH = 25;
    localparam int T_EL = 25;
    localparam int MAXP = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rs_sel = 1'b0;
    logic       busy_poll = 1'b0;
    logic [7:0] db_val = 8'h00;
    logic       poll_mode = 1'b0;
    logic [7:0] lcd_db_in;
    logic       lcd_rs, lcd_rw, lcd_e, rd_active, busy_flag, valid, timeout, done;
    logic [7:0] rd_data;
    logic [6:0] addr_cnt;

    int checks = 0;
    int errors = 0;
    int e_rises = 0;
    int e_base = 0;
    int e_width = 0;
    int valid_cnt = 0;
    int stable = 0;
    logic e_prev = 1'b0;
    logic rs_prev = 1'b0;
    logic rw_prev = 1'b0;
    logic rs0_seen = 1'b0;

    always #5 clk = ~clk;

    assign lcd_db_in = poll_mode ? (((e_rises - e_base) <= 3) ? 8'h80 : 8'h05) : db_val;

    lcd_read_fsm #(
        .T_AS(T_AS), .T_EH(T_EH), .T_EL(T_EL), .MAX_POLLS(MAXP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .rs_sel(rs_sel), .busy_poll(busy_poll),
        .lcd_db_in(lcd_db_in), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .rd_active(rd_active), .rd_data(rd_data), .busy_flag(busy_flag), .addr_cnt(addr_cnt),
        .valid(valid), .timeout(timeout), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus protocol monitor: E width, RS/RW setup before E, RS/RW frozen while E high.
    always @(negedge clk) begin
        if (reset) begin
            e_prev = 1'b0;
            stable = 0;
        end else begin
            if ((lcd_rs !== rs_prev) || (lcd_rw !== rw_prev)) stable = 0;
            else stable++;
            if (lcd_e && !e_prev) begin
                e_rises++;
                e_width = 1;
                chk("rsrw_setup", 32'(stable >= T_AS), 1);
                chk("rw_high_at_e", 32'(lcd_rw), 1);
            end else if (lcd_e) begin
                e_width++;
                chk("rsrw_frozen", 32'(stable != 0), 1);
            end
            if (!lcd_e && e_prev) chk("e_width", e_width, T_EH);
            if (valid) valid_cnt++;
            if (rd_active && !lcd_rs) rs0_seen = 1'b1;
            e_prev = lcd_e;
        end
        rs_prev = lcd_rs;
        rw_prev = lcd_rw;
    end

    task automatic start_op(input logic rs, input logic poll);
        @(negedge clk);
        rs_sel = rs;
        busy_poll = poll;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges from the start-sampling edge (edge 1) to the edge that raised valid.
    task automatic wait_valid(output int lat);
        bit seen;
        seen = 0;
        lat = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (valid) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (!seen) chk("valid_wait_expired", 0, 1);
    endtask

    int lat;
    int v0;
    int e0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_e", lcd_e, 0);
        chk("rst_active", rd_active, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_bf", busy_flag, 0);
        chk("rst_ac", addr_cnt, 0);
        chk("rst_valid", valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_done", done, 1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single instruction-register read
        db_val = 8'h25;
        v0 = valid_cnt; e0 = e_rises;
        start_op(1'b0, 1'b0);
        wait_valid(lat);
        chk("t1_latency", lat, 55);
        chk("t1_rd_data", rd_data, 8'h25);
        chk("t1_bf", busy_flag, 0);
        chk("t1_ac", addr_cnt, 7'h25);
        chk("t1_timeout", timeout, 0);
        @(negedge clk);
        chk("t1_valid_pulse", valid, 0);
        chk("t1_done", done, 1);
        chk("t1_rw_idle", lcd_rw, 0);
        chk("t1_pulses", e_rises - e0, 1);

        // Data-RAM read with a stray start mid-operation
        db_val = 8'h41;
        rs0_seen = 1'b0;
        v0 = valid_cnt; e0 = e_rises;
        start_op(1'b1, 1'b1);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(lat);
        chk("t2_rd_data", rd_data, 8'h41);
        chk("t2_bf_kept", busy_flag, 0);
        chk("t2_ac_kept", addr_cnt, 7'h25);
        chk("t2_rs_high", rs0_seen, 0);
        repeat (70) @(negedge clk);
        chk("t2_one_valid", valid_cnt - v0, 1);
        chk("t2_one_pulse", e_rises - e0, 1);
        chk("t2_done", done, 1);

        // Busy polling that clears on the fourth read
        poll_mode = 1'b1;
        e_base = e_rises;
        v0 = valid_cnt;
        start_op(1'b0, 1'b1);
        wait_valid(lat);
        chk("t3_rd_data", rd_data, 8'h05);
        chk("t3_bf", busy_flag, 0);
        chk("t3_ac", addr_cnt, 7'h05);
        chk("t3_timeout", timeout, 0);
        repeat (5) @(negedge clk);
        chk("t3_pulses", e_rises - e_base, 4);
        chk("t3_one_valid", valid_cnt - v0, 1);
        poll_mode = 1'b0;

        // Busy flag stuck: timeout after MAX_POLLS reads
        db_val = 8'h80;
        e0 = e_rises; v0 = valid_cnt;
        start_op(1'b0, 1'b1);
        wait_valid(lat);
        chk("t4_timeout", timeout, 1);
        chk("t4_bf", busy_flag, 1);
        chk("t4_ac", addr_cnt, 0);
        repeat (5) @(negedge clk);
        chk("t4_pulses", e_rises - e0, 4);
        chk("t4_one_valid", valid_cnt - v0, 1);

        // start held high: back-to-back reads, timeout cleared by the next start
        db_val = 8'h3A;
        v0 = valid_cnt;
        @(negedge clk);
        rs_sel = 1'b0;
        busy_poll = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("t5_timeout_clr", timeout, 0);
        wait_valid(lat);
        chk("t5_ac", addr_cnt, 7'h3A);
        @(negedge clk);
        chk("t5_idle_gap", done, 1);
        @(negedge clk);
        chk("t5_restart", done, 0);
        start = 1'b0;
        wait_valid(lat);
        repeat (5) @(negedge clk);
        chk("t5_two_valid", valid_cnt - v0, 2);
        chk("t5_done", done, 1);

        // Reset in the middle of E high
        db_val = 8'h99;
        start_op(1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (lcd_e) break;
            @(negedge clk);
        end
        chk("t6_e_reached", lcd_e, 1);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_e_async", lcd_e, 0);
        chk("t6_rw_async", lcd_rw, 0);
        chk("t6_done", done, 1);
        chk("t6_active", rd_active, 0);
        v0 = valid_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (80) @(negedge clk);
        chk("t6_no_valid", valid_cnt - v0, 0);
        chk("t6_rd_data", rd_data, 0);
        chk("t6_idle", done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
